mips_mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port unified memory between the MIPS instruction-fetch path and the load/store data path. It sits between the core's fetch/data interfaces and the memory. It serialises accesses through a small FSM with a bounded wait per transaction. Each requester sees a simple req/ack handshake; the memory sees one request at a time with registered address, write-data and write-enable.

---
 rtl/mips_mem_arbiter_if.sv | 35 +++
 rtl/mips_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of the unified-memory arbiter.
// The slave modport is the arbiter's view; the master modport is the core/memory view.
// Carries no logic of its own.
interface mips_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_ack, if_rdata, d_ack, d_rdata, err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_ack, if_rdata, d_ack, d_rdata, err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Purpose: shares one single-port memory between MIPS fetch and load/store; optional ARB_ROUND_ROBIN_EN.
// Latency: request sampled in IDLE, ack one cycle after mem_ready (or after TIMEOUT_CYC busy cycles with err).
// Backpressure: requesters hold req until their one-cycle ack; one memory access in flight at a time.
module mips_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input logic            clk,
  input logic            rst_n,
  mips_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic {OWN_F, OWN_D} owner_t;

  // Compare against count+1 in 9 bits so TIMEOUT_CYC = 255 cannot wrap.
  localparam logic [8:0] TO_LIM = 9'(TIMEOUT_CYC);

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [8:0]        cnt_inc;
  logic              grant_d;
  logic              mem_req_q, mem_req_nxt;
  logic              mem_we_q, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nxt;
  logic              if_ack_q, if_ack_nxt;
  logic              d_ack_q, d_ack_nxt;
  logic              err_q, err_nxt;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_nxt;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_nxt;
`ifdef ARB_ROUND_ROBIN_EN
  owner_t            last, last_nxt;
`endif

  assign cnt_inc = {1'b0, cnt} + 9'd1;

  // Grant decision in IDLE: round robin on contention, otherwise D has fixed priority.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    grant_d = bus.d_req && (!bus.if_req || (last == OWN_F));
`else
    grant_d = bus.d_req;
`endif
  end

  // Next-state and next-output logic; every output is a register fed from here.
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    cnt_nxt       = cnt;
    mem_req_nxt   = 1'b0;
    mem_we_nxt    = mem_we_q;
    mem_addr_nxt  = mem_addr_q;
    mem_wdata_nxt = mem_wdata_q;
    if_ack_nxt    = 1'b0;
    d_ack_nxt     = 1'b0;
    err_nxt       = 1'b0;
    if_rdata_nxt  = if_rdata_q;
    d_rdata_nxt   = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_nxt      = last;
`endif
    unique case (state)
      S_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          state_nxt   = S_BUSY;
          cnt_nxt     = '0;
          mem_req_nxt = 1'b1;
          if (grant_d) begin
            owner_nxt     = OWN_D;
            mem_we_nxt    = bus.d_we;
            mem_addr_nxt  = bus.d_addr;
            mem_wdata_nxt = bus.d_wdata;
          end else begin
            owner_nxt     = OWN_F;
            mem_we_nxt    = 1'b0;
            mem_addr_nxt  = bus.if_addr;
            mem_wdata_nxt = '0;
          end
`ifdef ARB_ROUND_ROBIN_EN
          last_nxt = grant_d ? OWN_D : OWN_F;
`endif
        end
      end
      S_BUSY: begin
        mem_req_nxt = 1'b1;
        cnt_nxt     = cnt_inc[7:0];
        // mem_ready wins over a timeout landing on the same edge.
        if (bus.mem_ready) begin
          state_nxt   = S_DONE;
          mem_req_nxt = 1'b0;
          if (owner == OWN_F) begin
            if_ack_nxt   = 1'b1;
            if_rdata_nxt = bus.mem_rdata;
          end else begin
            d_ack_nxt = 1'b1;
            if (!mem_we_q) d_rdata_nxt = bus.mem_rdata;
          end
        end else if (cnt_inc >= TO_LIM) begin
          state_nxt   = S_DONE;
          mem_req_nxt = 1'b0;
          err_nxt     = 1'b1;
          if (owner == OWN_F) if_ack_nxt = 1'b1;
          else                d_ack_nxt  = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops mem_req and clears all visible state at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      owner       <= OWN_D;
      cnt         <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last        <= OWN_D;
`endif
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      cnt         <= cnt_nxt;
      mem_req_q   <= mem_req_nxt;
      mem_we_q    <= mem_we_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
      if_ack_q    <= if_ack_nxt;
      d_ack_q     <= d_ack_nxt;
      err_q       <= err_nxt;
      if_rdata_q  <= if_rdata_nxt;
      d_rdata_q   <= d_rdata_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      last        <= last_nxt;
`endif
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.err       = err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: directed scenarios then randomized traffic against a transaction-level model.
// Memory responder answers after a programmable latency (0 = never answers).
// Model predicts grant order, ack timing, err and read data from the arbitration rules.
module tb_mips_mem_arbiter;
  localparam int TO = 4;

  logic clk;
  logic rst_n;
  mips_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // memory responder
  int          lat = 1;
  int          age = 0;
  logic        resp_ready = 1'b0;
  logic        force_ready = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic [31:0] ram  [logic [31:0]];
  // reference model
  logic [31:0] mmem [logic [31:0]];
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata  = '0;
  bit          model_last_d = 1'b1;

  assign bus.mem_ready = resp_ready | force_ready;
  assign bus.mem_rdata = resp_rdata;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] mval(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    #2;
    if (!rst_n || !bus.mem_req) begin
      age = 0;
      resp_ready = 1'b0;
    end else begin
      age++;
      if (lat != 0 && age == lat) begin
        resp_ready = 1'b1;
        resp_rdata = ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : init_word(bus.mem_addr);
        if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
      end else begin
        resp_ready = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    ram[a]  = v;
    mmem[a] = v;
  endtask

  // One arbitration round: apply the requests, expect each grant in model order.
  task automatic run(input bit rf, input bit rd, input logic [31:0] fa, input logic [31:0] da,
                     input bit we, input logic [31:0] wd, input int lat_i, input bit stale);
    bit first_d;
    bit is_d;
    int n;
    int cyc;
    int leff;
    bit got;
    n = int'(rf) + int'(rd);
    leff = (lat_i == 0 || lat_i > TO) ? TO : lat_i;
`ifdef ARB_ROUND_ROBIN_EN
    first_d = rd && (!rf || !model_last_d);
`else
    first_d = rd;
`endif
    bus.if_req = rf; bus.if_addr = fa;
    bus.d_req = rd; bus.d_we = we; bus.d_addr = da; bus.d_wdata = wd;
    lat = lat_i;
    force_ready = stale;
    for (int k = 0; k < n; k++) begin
      is_d = (k == 0) ? first_d : !first_d;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 40) begin
        tick();
        cyc++;
        if (k == 0 && cyc == 1) force_ready = 1'b0;
        if (cyc == k + 1) begin
          check("busy_mem_req", 64'(bus.mem_req), 64'd1);
          check("busy_mem_addr", 64'(bus.mem_addr), 64'(is_d ? da : fa));
          check("busy_mem_we", 64'(bus.mem_we), 64'(is_d ? we : 1'b0));
          check("busy_mem_wdata", 64'(bus.mem_wdata), 64'(is_d ? wd : 32'h0));
        end
        if (bus.if_ack || bus.d_ack) got = 1'b1;
      end
      check("ack_latency", 64'(cyc), 64'(leff + 1 + k));
      check("ack_owner", 64'({bus.if_ack, bus.d_ack}), 64'(is_d ? 2'b01 : 2'b10));
      check("err", 64'(bus.err), 64'(lat_i == 0 || lat_i > TO));
      check("done_mem_req", 64'(bus.mem_req), 64'd0);
      if (!(lat_i == 0 || lat_i > TO)) begin
        if (is_d && we) mmem[da] = wd;
        else if (is_d)  exp_d_rdata = mval(da);
        else            exp_if_rdata = mval(fa);
      end
      check("if_rdata", 64'(bus.if_rdata), 64'(exp_if_rdata));
      check("d_rdata", 64'(bus.d_rdata), 64'(exp_d_rdata));
      model_last_d = is_d;
      if (is_d) bus.d_req = 1'b0;
      else      bus.if_req = 1'b0;
    end
    tick();
    check("ack_pulse_end", 64'({bus.if_ack, bus.d_ack, bus.err}), 64'd0);
  endtask

  initial begin
    logic [31:0] a3 [3];
    bit rf, rd;
    int cyc;
    bit got;
    rst_n = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    // reset state
    #12;
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_acks_err", 64'({bus.if_ack, bus.d_ack, bus.err}), 64'd0);
    check("rst_mem_bus", 64'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'd0);
    check("rst_rdata", 64'({bus.if_rdata, bus.d_rdata}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // single fetch
    preload(32'h40, 32'h8C22_0004);
    run(1, 0, 32'h40, 32'h0, 0, 32'h0, 1, 0);
    check("fetch_word", 64'(bus.if_rdata), 64'h8C22_0004);

    // store then load
    run(0, 1, 32'h0, 32'h100, 1, 32'hDEAD_BEEF, 1, 0);
    run(0, 1, 32'h0, 32'h100, 0, 32'h0, 2, 0);
    check("load_word", 64'(bus.d_rdata), 64'hDEAD_BEEF);

    // contention, then a lone fetch, then contention again
    run(1, 1, 32'h44, 32'h104, 0, 32'h0, 1, 0);
    run(1, 0, 32'h48, 32'h0, 0, 32'h0, 1, 0);
    run(1, 1, 32'h4C, 32'h108, 1, 32'h1234_5678, 2, 0);

    // timeout, then a normal transaction; ready on the timeout edge still succeeds
    run(1, 0, 32'h50, 32'h0, 0, 32'h0, 0, 0);
    run(1, 0, 32'h54, 32'h0, 0, 32'h0, 1, 0);
    run(0, 1, 32'h0, 32'h108, 0, 32'h0, TO, 0);

    // reset in the middle of a long fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h200; lat = 10;
    tick(); tick();
    check("pre_rst_mem_req", 64'(bus.mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_req", 64'(bus.mem_req), 64'd0);
    check("midrst_outs", 64'({bus.if_ack, bus.d_ack, bus.err, bus.mem_we, bus.mem_addr}), 64'd0);
    check("midrst_rdata", 64'({bus.if_rdata, bus.d_rdata}), 64'd0);
    exp_if_rdata = '0; exp_d_rdata = '0; model_last_d = 1'b1;
    tick();
    rst_n = 1'b1;
    run(1, 0, 32'h200, 32'h0, 0, 32'h0, 2, 1);

    // back-to-back fetches with req held
    a3[0] = 32'h300; a3[1] = 32'h304; a3[2] = 32'h308;
    lat = 2; bus.if_req = 1'b1; bus.if_addr = a3[0];
    for (int t = 0; t < 3; t++) begin
      cyc = 0; got = 1'b0;
      while (!got && cyc < 40) begin
        tick();
        cyc++;
        if (cyc == ((t == 0) ? 1 : 2)) check("b2b_mem_addr", 64'(bus.mem_addr), 64'(a3[t]));
        if (bus.if_ack) got = 1'b1;
      end
      check("b2b_spacing", 64'(cyc), 64'((t == 0) ? 3 : 4));
      exp_if_rdata = mval(a3[t]);
      check("b2b_rdata", 64'(bus.if_rdata), 64'(exp_if_rdata));
      if (t < 2) bus.if_addr = a3[t + 1];
    end
    bus.if_req = 1'b0;
    model_last_d = 1'b0;
    tick();

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      rf = 1'b0; rd = 1'b0;
      while (!rf && !rd) begin
        rf = 1'($urandom_range(0, 1));
        rd = 1'($urandom_range(0, 1));
      end
      run(rf, rd, 32'h1000 + 32'($urandom_range(0, 15)) * 4, 32'h1000 + 32'($urandom_range(0, 15)) * 4,
          1'($urandom_range(0, 1)), $urandom, $urandom_range(0, TO), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
